// File: rtl/add_mul_sub_pkg.sv
// Shared types for the sequential add/sub/mul unit.
//   op_e    : operation encoding presented on the 'operation' port
//   state_e : control FSM states of add_mul_sub_seq
package add_mul_sub_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

endpackage

// File: rtl/add_mul_sub_mul_step.sv
// One combinational shift-add multiply step.
//   acc        in   2*WIDTH+1  running accumulator (extra top bit holds the add carry)
//   mplier     in   WIDTH      remaining multiplier bits, LSB examined this step
//   mcand      in   WIDTH      multiplicand
//   acc_nxt    out  2*WIDTH+1  accumulator after optional add and right shift
//   mplier_nxt out  WIDTH      multiplier shifted right by one
module add_mul_sub_mul_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);

  logic [2*WIDTH:0] addend;
  logic [2*WIDTH:0] sum;

  // Multiplicand enters the upper half; after WIDTH right shifts each partial
  // product lands at its proper weight.
  assign addend     = mplier[0] ? {1'b0, mcand, {WIDTH{1'b0}}} : '0;
  assign sum        = acc + addend;
  assign acc_nxt    = sum >> 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/add_mul_sub_seq.sv
// Handshaked add/sub/mul unit. Operands are captured on accept; add, sub and
// NOP complete in one cycle, unsigned multiply iterates WIDTH shift-add steps.
// The result is held until the consumer takes it.
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   a, b       in   WIDTH    unsigned operands
//   operation  in   2        00 NOP, 01 add, 10 sub (a-b), 11 mul
//   in_valid   in   1        request present
//   in_ready   out  1        unit idle and able to accept
//   Result     out  2*WIDTH  result, stable while out_valid
//   out_valid  out  1        Result valid
//   out_ready  in   1        consumer takes Result
//   busy       out  1        unit not idle
module add_mul_sub_seq
  import add_mul_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           operation,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   Result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int unsigned R  = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [R:0]       acc;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mcand;
  logic [R:0]       acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic             accept;
  op_e              op_in;
  logic [R-1:0]     a_ext, b_ext;

  assign op_in     = op_e'(operation);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid & in_ready;
  assign a_ext     = {{WIDTH{1'b0}}, a};
  assign b_ext     = {{WIDTH{1'b0}}, b};

  add_mul_sub_mul_step #(
    .WIDTH (WIDTH)
  ) u_mul_step (
    .acc        (acc),
    .mplier     (mplier),
    .mcand      (mcand),
    .acc_nxt    (acc_nxt),
    .mplier_nxt (mplier_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (op_in == OP_MUL) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result is only written when an answer is ready: on accept for add/sub/NOP,
  // on the last step for mul. While multiplying it keeps its old value, which
  // is harmless because out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      Result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            unique case (op_in)
              OP_ADD:  Result <= a_ext + b_ext;
              OP_SUB:  Result <= a_ext - b_ext;
              OP_MUL:  Result <= Result;
              default: Result <= '0;
            endcase
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            Result <= acc_nxt[R-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_mul_sub_seq.sv
module tb_add_mul_sub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]  a4, b4;
  logic [1:0]  op4;
  logic        iv4, ir4, ov4, or4, busy4;
  logic [7:0]  res4;

  logic [7:0]  a8, b8;
  logic [1:0]  op8;
  logic        iv8, ir8, ov8, or8, busy8;
  logic [15:0] res8;

  int errors = 0;
  int checks = 0;

  add_mul_sub_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .operation(op4),
    .in_valid(iv4), .in_ready(ir4), .Result(res4), .out_valid(ov4),
    .out_ready(or4), .busy(busy4)
  );

  add_mul_sub_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .operation(op8),
    .in_valid(iv8), .in_ready(ir8), .Result(res8), .out_valid(ov8),
    .out_ready(or8), .busy(busy8)
  );

  // Reference: plain arithmetic modulo 2^(2w).
  function automatic int ref_model(input int w, input int op, input int x, input int y);
    int mask;
    mask = (1 << (2 * w)) - 1;
    case (op)
      1:       return (x + y) & mask;
      2:       return (x - y) & mask;
      3:       return (x * y) & mask;
      default: return 0;
    endcase
  endfunction

  // Issue one op; 'edges' = rising edges after the accept edge until out_valid.
  task automatic issue4(input int x, input int y, input int op,
                        output int edges, output bit busy_ok);
    int guard;
    guard = 0;
    busy_ok = 1'b1;
    while (!ir4 && guard < 100) begin @(posedge clk); #1; guard++; end
    a4 = x[3:0]; b4 = y[3:0]; op4 = op[1:0]; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    edges = 0;
    while (!ov4 && edges < 100) begin
      if (!busy4) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic issue8(input int x, input int y, input int op, output int edges);
    int guard;
    guard = 0;
    while (!ir8 && guard < 100) begin @(posedge clk); #1; guard++; end
    a8 = x[7:0]; b8 = y[7:0]; op8 = op[1:0]; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    edges = 0;
    while (!ov8 && edges < 100) begin @(posedge clk); #1; edges++; end
  endtask

  task automatic retire4();
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
  endtask

  task automatic retire8();
    or8 = 1'b1; @(posedge clk); #1; or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (res4 !== 8'h00) begin errors++; $display("FAIL reset_result4 got=%h exp=%h", res4, 8'h00); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got=%b exp=0", ov4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4 got=%b exp=1", ir4); end
    checks++; if (res8 !== 16'h0000) begin errors++; $display("FAIL reset_result8 got=%h exp=%h", res8, 16'h0000); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got=%b exp=0", ov8); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int e; bit bok;
    issue4(15, 15, 1, e, bok);
    checks++; if (e !== 0) begin errors++; $display("FAIL add_latency got=%0d exp=0", e); end
    checks++; if (res4 !== 8'h1E) begin errors++; $display("FAIL add_15_15 got=%h exp=1e", res4); end
    retire4();
  endtask

  task automatic test_sub();
    int e; bit bok;
    issue4(3, 5, 2, e, bok);
    checks++; if (res4 !== 8'hFE) begin errors++; $display("FAIL sub_3_5 got=%h exp=fe", res4); end
    checks++; if (e !== 0) begin errors++; $display("FAIL sub_latency got=%0d exp=0", e); end
    retire4();
    issue4(9, 9, 2, e, bok);
    checks++; if (res4 !== 8'h00) begin errors++; $display("FAIL sub_9_9 got=%h exp=00", res4); end
    retire4();
    issue4(9, 4, 0, e, bok);
    checks++; if (res4 !== 8'h00) begin errors++; $display("FAIL nop got=%h exp=00", res4); end
    retire4();
  endtask

  task automatic test_mul();
    int edges;
    bit busy_ok, ir_seen;
    busy_ok = 1'b1; ir_seen = 1'b0;
    a4 = 4'd15; b4 = 4'd15; op4 = 2'b11; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    edges = 0;
    while (!ov4 && edges < 100) begin
      if (!busy4) busy_ok = 1'b0;
      if (ir4) ir_seen = 1'b1;
      // stray requests while multiplying must not disturb the result
      a4 = 4'd1; b4 = 4'd2; op4 = 2'b01; iv4 = (edges % 2 == 0);
      @(posedge clk); #1;
      edges++;
    end
    iv4 = 1'b0;
    checks++; if (edges !== 4) begin errors++; $display("FAIL mul_latency got=%0d exp=4", edges); end
    checks++; if (res4 !== 8'hE1) begin errors++; $display("FAIL mul_15_15 got=%h exp=e1", res4); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL mul_busy got=%b exp=1", busy_ok); end
    checks++; if (ir_seen !== 1'b0) begin errors++; $display("FAIL mul_in_ready got=%b exp=0", ir_seen); end
    retire4();
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL mul_no_extra_result got=%b exp=0", ov4); end
  endtask

  task automatic test_backpressure();
    int e; bit bok;
    issue4(6, 7, 3, e, bok);
    checks++; if (e !== 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", e); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL bp_busy got=%b exp=1", bok); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (res4 !== 8'h2A) begin errors++; $display("FAIL bp_hold_result cyc=%0d got=%h exp=2a", i, res4); end
      checks++; if (ir4 !== 1'b0 || ov4 !== 1'b1) begin errors++; $display("FAIL bp_hold_flags cyc=%0d got ir=%b ov=%b exp ir=0 ov=1", i, ir4, ov4); end
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", ir4, ov4); end
  endtask

  task automatic test_out_ready_early();
    int e; bit bok;
    or4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL early_ready_idle got ov=%b ir=%b exp ov=0 ir=1", ov4, ir4); end
    issue4(5, 9, 1, e, bok);
    checks++; if (e !== 0 || res4 !== 8'h0E) begin errors++; $display("FAIL early_ready_add got lat=%0d res=%h exp lat=0 res=0e", e, res4); end
    @(posedge clk); #1;
    or4 = 1'b0;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL early_ready_retire got=%b exp=1", ir4); end
  endtask

  task automatic test_reset_mid_mul();
    int e; bit bok;
    a4 = 4'd15; b4 = 4'd15; op4 = 2'b11; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_mul_out_valid got=%b exp=0", ov4); end
    checks++; if (res4 !== 8'h00) begin errors++; $display("FAIL rst_mul_result got=%h exp=00", res4); end
    checks++; if (busy4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL rst_mul_state got busy=%b ir=%b exp busy=0 ir=1", busy4, ir4); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue4(2, 3, 3, e, bok);
    checks++; if (e !== 4 || res4 !== 8'h06) begin errors++; $display("FAIL rst_then_mul got lat=%0d res=%h exp lat=4 res=06", e, res4); end
    retire4();
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int n_out, x, y, op, exp;
    n_out = 0;
    or4 = 1'b1; iv4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ir4) begin
        x = $urandom_range(0, 15); y = $urandom_range(0, 15); op = $urandom_range(1, 2);
        a4 = x[3:0]; b4 = y[3:0]; op4 = op[1:0];
        exp_q.push_back(ref_model(4, op, x, y));
      end
      @(posedge clk); #1;
      if (ov4) begin
        n_out++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if (res4 !== exp[7:0] || exp < 0) begin errors++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", n_out, res4, exp[7:0]); end
      end
    end
    iv4 = 1'b0; or4 = 1'b0;
    @(posedge clk); #1;
    checks++; if (n_out !== 10) begin errors++; $display("FAIL b2b_throughput got=%0d exp=10", n_out); end
  endtask

  task automatic test_width8_sweep();
    int e, x, y, op, exp, exp_lat;
    issue8(255, 255, 3, e);
    checks++; if (e !== 8 || res8 !== 16'hFE01) begin errors++; $display("FAIL w8_mul_max got lat=%0d res=%h exp lat=8 res=fe01", e, res8); end
    retire8();
    issue8(0, 1, 2, e);
    checks++; if (e !== 0 || res8 !== 16'hFFFF) begin errors++; $display("FAIL w8_sub_0_1 got lat=%0d res=%h exp lat=0 res=ffff", e, res8); end
    retire8();
    issue8(0, 200, 3, e);
    checks++; if (e !== 8 || res8 !== 16'h0000) begin errors++; $display("FAIL w8_mul_zero got lat=%0d res=%h exp lat=8 res=0000", e, res8); end
    retire8();
    for (int i = 0; i < 30; i++) begin
      x = $urandom_range(0, 255); y = $urandom_range(0, 255); op = $urandom_range(0, 3);
      exp = ref_model(8, op, x, y);
      exp_lat = (op == 3) ? 8 : 0;
      issue8(x, y, op, e);
      checks++; if (res8 !== exp[15:0] || e !== exp_lat) begin
        errors++;
        $display("FAIL w8_random op=%0d a=%0d b=%0d got lat=%0d res=%h exp lat=%0d res=%h", op, x, y, e, res8, exp_lat, exp[15:0]);
      end
      retire8();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a4 = '0; b4 = '0; op4 = '0; iv4 = 1'b0; or4 = 1'b0;
    a8 = '0; b8 = '0; op8 = '0; iv8 = 1'b0; or8 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_out_ready_early();
    test_reset_mid_mul();
    test_back_to_back();
    test_width8_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
